read_responder: RTL

Target-side partner of the team's one-hot read-initiator FSM, which drives `rd` and `ds` and samples `ws`. It accepts a read strobe, captures an address, and inserts a programmable number of wait states by holding `ws` high. It then presents data from an internal register array and closes the transaction on the initiator's done strobe. It sits on the target side of the initiator's `rd`/`ws`/`ds` handshake and also exposes a simple write port for loading the array.

---
 rtl/read_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/read_responder.sv
// Read target for the one-hot read initiator: captures an address on rd, holds ws for wait_cfg cycles, then returns mem[addr].
// Latency: data valid (rvalid) in cycle wait_cfg+1 after the edge that first samples rd in IDLE; rd_count/err update one edge after ds/rd drop.
// Backpressure: ws high stalls the initiator; completion requires a ds pulse with rd low, otherwise err is raised.
//
// Ports:
//   clk, rstn            clock and async active-low reset
//   rd, ds, addr,        initiator handshake: read strobe, done pulse, read address,
//   wait_cfg             and number of wait states for the read being started
//   ws, rdata, rvalid    wait flag, read data, read-data valid
//   we, waddr, wdata     array write port (accepted in any state)
//   err, err_clr         sticky protocol-error flag and its synchronous clear
//   rd_count             completed-read counter, wraps at 256
module read_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd,
    input  logic              ds,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              ws,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        rd_count
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              err_set;

    // Any exit from BUSY other than ds with the wait count exhausted is a
    // protocol error: either an abort (ds low) or a premature done.
    assign err_set = (state == BUSY) && !rd && !(ds && (cnt == '0));

    // Outputs decode registered state only, so the initiator never sees a
    // combinational path from its own strobes back to ws.
    assign ws     = (state == BUSY) && (cnt != '0);
    assign rvalid = (state == BUSY) && (cnt == '0);

    // Register array. rdata is loaded in the other block from the pre-edge
    // contents, which gives read-before-write on a same-edge collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            rd_count <= '0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // ds while idle is deliberately ignored.
                    if (rd) begin
                        addr_q <= addr;
                        cnt    <= wait_cfg;
                        state  <= BUSY;
                        if (wait_cfg == '0) begin
                            rdata <= mem[addr];
                        end
                    end
                end
                BUSY: begin
                    if (rd) begin
                        // The initiator toggles between its READ and DELAY
                        // states while rd stays high; the count runs anyway.
                        if (cnt != '0) begin
                            cnt <= cnt - WAIT_W'(1);
                            if (cnt == WAIT_W'(1)) begin
                                rdata <= mem[addr_q];
                            end
                        end
                    end else begin
                        state <= IDLE;
                        if (ds && (cnt == '0)) begin
                            rd_count <= rd_count + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
